// File: rtl/ac97_frame_tx_pkg.sv
// ac97_frame_tx_pkg
// Shared AC'97 output-frame geometry: frame/tag/slot widths, tag bit
// positions, slot indices, the command record type and slot-packing helpers.
package ac97_frame_tx_pkg;

  localparam int AC97_FRAME_BITS = 256;
  localparam int AC97_TAG_BITS   = 16;
  localparam int AC97_SLOT_BITS  = 20;
  localparam int AC97_NUM_SLOTS  = 12;

  // Tag bit positions (bit 15 is transmitted first)
  localparam int TAG_FRAME_VALID = 15;
  localparam int TAG_CMD_ADDR    = 14;
  localparam int TAG_CMD_DATA    = 13;
  localparam int TAG_PCM_L       = 12;
  localparam int TAG_PCM_R       = 11;

  // Slot indices carried by this transmitter
  localparam int SLOT_CMD_ADDR = 1;
  localparam int SLOT_CMD_DATA = 2;
  localparam int SLOT_PCM_L    = 3;
  localparam int SLOT_PCM_R    = 4;

  // Slots 5..12 are always transmitted as zero
  localparam int UNUSED_SLOT_BITS = (AC97_NUM_SLOTS - SLOT_PCM_R) * AC97_SLOT_BITS;

  typedef logic [7:0]                  cnt_t;
  typedef logic [AC97_FRAME_BITS-1:0]  frame_t;
  typedef logic [AC97_TAG_BITS-1:0]    tag_t;
  typedef logic [AC97_SLOT_BITS-1:0]   slot_t;

  localparam cnt_t CNT_LAST = 8'd255;
  localparam cnt_t SYNC_END = 8'd16;

  typedef struct packed {
    logic        rw;     // 1 = register read
    logic [6:0]  addr;
    logic [15:0] data;
  } ac97_cmd_t;

  // Slot 1: read/write flag, register index, then 12 reserved zero bits
  function automatic slot_t cmd_addr_slot(input ac97_cmd_t c);
    return {c.rw, c.addr, 12'h000};
  endfunction

  // Slot 2: 16-bit write data left-justified in the 20-bit slot
  function automatic slot_t cmd_data_slot(input ac97_cmd_t c);
    return {c.data, 4'h0};
  endfunction

endpackage

// File: rtl/ac97_cmd_holder.sv
// ac97_cmd_holder
// One-deep codec command holding register with valid/ready handshake.
// Ports:
//   clk_i, rst_ni   - bit clock, asynchronous active-low reset
//   cmd_valid_i     - upstream offers cmd_i
//   cmd_i           - command record (rw/addr/data)
//   clear_i         - frame capture edge; empties the register if it is full
//   cmd_ready_o     - register empty, a command may be accepted
//   pending_o       - register full, command waits for the next capture edge
//   cmd_o           - held command record
module ac97_cmd_holder
  import ac97_frame_tx_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      cmd_valid_i,
  input  ac97_cmd_t cmd_i,
  input  logic      clear_i,
  output logic      cmd_ready_o,
  output logic      pending_o,
  output ac97_cmd_t cmd_o
);

  logic      pending_q, pending_d;
  logic      accept;
  ac97_cmd_t cmd_q;

  assign accept = cmd_valid_i & ~pending_q;

  // Accept can only happen while empty, so accept and clear never
  // conflict: a capture with an empty register leaves the new command
  // pending for the following frame.
  always_comb begin
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Command fields are only observed while pending, so they carry no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      cmd_q <= cmd_i;
    end
  end

  assign cmd_ready_o = ~pending_q;
  assign pending_o   = pending_q;
  assign cmd_o       = cmd_q;

endmodule

// File: rtl/ac97_frame_tx.sv
// ac97_frame_tx
// Serializes one 256-bit AC'97 output frame per frame period onto SYNC /
// SDATA_OUT. Slots 3/4 carry a stereo 20-bit PCM pair, slots 1/2 an optional
// codec register command from a one-deep holding register.
// Ports:
//   I_BITCLK        - codec bit clock (only clock)
//   I_RESET_L       - asynchronous active-low reset
//   I_PCM_EN        - transmit and mark valid slots 3/4
//   I_LEFT_SAMPLE   - left PCM sample, two's complement
//   I_RIGHT_SAMPLE  - right PCM sample, two's complement
//   I_CMD_VALID/RW/ADDR/DATA, O_CMD_READY - command handshake
//   O_STROBE        - one-cycle pulse at cnt 0, samples just captured
//   O_SYNC          - high for cnt 0..15
//   O_SDATA         - serial frame data, MSB first
module ac97_frame_tx
  import ac97_frame_tx_pkg::*;
(
  input  logic                I_BITCLK,
  input  logic                I_RESET_L,
  input  logic                I_PCM_EN,
  input  logic signed [19:0]  I_LEFT_SAMPLE,
  input  logic signed [19:0]  I_RIGHT_SAMPLE,
  input  logic                I_CMD_VALID,
  input  logic                I_CMD_RW,
  input  logic [6:0]          I_CMD_ADDR,
  input  logic [15:0]         I_CMD_DATA,
  output logic                O_CMD_READY,
  output logic                O_STROBE,
  output logic                O_SYNC,
  output logic                O_SDATA
);

  cnt_t      cnt_q, cnt_d;
  logic      sync_q, sync_d;
  logic      strobe_q, strobe_d;
  frame_t    shift_q, shift_d;
  frame_t    frame;
  tag_t      tag;
  slot_t     slot_cmd_addr, slot_cmd_data, slot_pcm_l, slot_pcm_r;
  logic      capture;
  logic      cmd_pending;
  ac97_cmd_t cmd_in, cmd_held;

  // The edge leaving cnt 255 starts a new frame and loads the shifter
  assign capture = (cnt_q == CNT_LAST);
  assign cmd_in  = {I_CMD_RW, I_CMD_ADDR, I_CMD_DATA};

  ac97_cmd_holder u_cmd_holder (
    .clk_i       (I_BITCLK),
    .rst_ni      (I_RESET_L),
    .cmd_valid_i (I_CMD_VALID),
    .cmd_i       (cmd_in),
    .clear_i     (capture),
    .cmd_ready_o (O_CMD_READY),
    .pending_o   (cmd_pending),
    .cmd_o       (cmd_held)
  );

  // Frame assembly from the pre-edge pending state and the live sample inputs
  always_comb begin
    tag                  = '0;
    tag[TAG_FRAME_VALID] = cmd_pending | I_PCM_EN;
    tag[TAG_CMD_ADDR]    = cmd_pending;
    tag[TAG_CMD_DATA]    = cmd_pending & ~cmd_held.rw;
    tag[TAG_PCM_L]       = I_PCM_EN;
    tag[TAG_PCM_R]       = I_PCM_EN;

    slot_cmd_addr = cmd_pending ? cmd_addr_slot(cmd_held) : '0;
    slot_cmd_data = (cmd_pending && !cmd_held.rw) ? cmd_data_slot(cmd_held) : '0;
    slot_pcm_l    = I_PCM_EN ? slot_t'(I_LEFT_SAMPLE)  : '0;
    slot_pcm_r    = I_PCM_EN ? slot_t'(I_RIGHT_SAMPLE) : '0;

    frame = {tag, slot_cmd_addr, slot_cmd_data, slot_pcm_l, slot_pcm_r,
             {UNUSED_SLOT_BITS{1'b0}}};
  end

  // Outputs are decoded from the next count so they line up with the bit
  // that shift_q presents in the same cycle.
  always_comb begin
    cnt_d    = cnt_q + 8'd1;
    sync_d   = (cnt_d < SYNC_END);
    strobe_d = (cnt_d == '0);
    shift_d  = capture ? frame : {shift_q[AC97_FRAME_BITS-2:0], 1'b0};
  end

  always_ff @(posedge I_BITCLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      cnt_q    <= CNT_LAST;
      sync_q   <= 1'b0;
      strobe_q <= 1'b0;
      shift_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      strobe_q <= strobe_d;
      shift_q  <= shift_d;
    end
  end

  assign O_SYNC   = sync_q;
  assign O_STROBE = strobe_q;
  assign O_SDATA  = shift_q[AC97_FRAME_BITS-1];

endmodule
